mcpu_fetch_pcgen: RTL and testbench

Instruction fetch front end, directly upstream of the instruction L1 cache.
- Holds the packet-aligned PC and issues one read per cycle to the il1c.
- Captures each returned 128-bit packet together with its PC into a small FIFO and presents it to decode over a valid/ready handshake.
- Handles redirects (branches, exceptions) by flushing the FIFO and discarding the packet of any read already in flight.

---
 rtl/mcpu_fetch_pcgen.sv | 167 ++++++++++++++++
 tb/tb_mcpu_fetch_pcgen.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mcpu_fetch_pcgen.sv
// ---------------------------------------------------------------------------
// mcpu_fetch_pcgen
//
// Instruction fetch front end sitting directly upstream of the il1c.
// Holds the packet-aligned PC, issues at most one il1c read per cycle,
// buffers each returned 128-bit packet with its PC in a small FIFO and
// presents the FIFO head to decode over a valid/ready handshake.
// Redirects flush the FIFO and squash the packet of any read in flight.
//
// Parameters
//   RESET_PC    byte address fetched first after reset (bits [3:0] ignored)
//   FIFO_DEPTH  packet buffer entries, 2..8 (3 sustains one packet per cycle)
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   fetch_en              0 stops new il1c reads (outstanding one completes)
//   redirect_valid/_pc    one-cycle restart request, packet address [31:4]
//   il1c_addr/_re         read address (the PC register) and read request
//   il1c_packet/_ready    returned packet, cache-not-stalled
//   f2d_valid/_ready      decode handshake on the FIFO head
//   f2d_packet/_pc        head packet and its packet address [31:4]
//
// Optional build macro MCPU_FETCH_PERF_CTR_EN adds perf_pkt_count (pops)
// and perf_il1c_stall_count (cycles with il1c_re & ~il1c_ready).
// ---------------------------------------------------------------------------
module mcpu_fetch_pcgen #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         fetch_en,
  input  logic         redirect_valid,
  input  logic [27:0]  redirect_pc,
  output logic [27:0]  il1c_addr,
  output logic         il1c_re,
  input  logic [127:0] il1c_packet,
  input  logic         il1c_ready,
  output logic         f2d_valid,
  input  logic         f2d_ready,
  output logic [127:0] f2d_packet,
  output logic [27:0]  f2d_pc
`ifdef MCPU_FETCH_PERF_CTR_EN
  ,
  output logic [31:0]  perf_pkt_count,
  output logic [31:0]  perf_il1c_stall_count
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   DEPTH_C  = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(FIFO_DEPTH - 1);

  // Request stage (p0): PC register driving the cache.
  logic [27:0]   pc_p0;
  // Return stage (p1): the one read the cache has accepted.
  logic          inflight_p1;
  logic [27:0]   ipc_p1;
  logic          kill_p1;

  // Packet FIFO
  logic [127:0]  mem_pkt [FIFO_DEPTH];
  logic [27:0]   mem_pc  [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW:0]   occ;

  logic accept;
  logic ret;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Credit: a read is only issued if its packet is guaranteed a FIFO slot,
  // counting the packet already in flight.
  assign occ       = {1'b0, count} + {{CW{1'b0}}, inflight_p1};
  assign il1c_re   = rst_n & fetch_en & ~redirect_valid & (occ < DEPTH_C);
  assign il1c_addr = pc_p0;

  assign accept = il1c_re & il1c_ready;
  assign ret    = inflight_p1 & il1c_ready;
  // A redirect squashes both the returning packet and any pop this cycle.
  assign push   = ret & ~kill_p1 & ~redirect_valid;
  assign pop    = f2d_valid & f2d_ready & ~redirect_valid;

  // Head outputs read zero whenever the FIFO is empty, which also gives
  // zero outputs in reset without resetting the storage array.
  assign f2d_valid  = (count != '0);
  assign f2d_packet = f2d_valid ? mem_pkt[rd_ptr] : '0;
  assign f2d_pc     = f2d_valid ? mem_pc[rd_ptr]  : '0;

  // ---- p0 -> p1 boundary: PC advance, in-flight tracking, FIFO control ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0       <= RESET_PC[31:4];
      inflight_p1 <= 1'b0;
      kill_p1     <= 1'b0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (redirect_valid)
        pc_p0 <= redirect_pc;
      else if (accept)
        pc_p0 <= pc_p0 + 28'd1;

      if (accept)
        inflight_p1 <= 1'b1;
      else if (ret)
        inflight_p1 <= 1'b0;

      // The cache cannot abort a read, so a redirect over an outstanding
      // read marks it to be dropped when it eventually returns.
      if (ret)
        kill_p1 <= 1'b0;
      else if (redirect_valid && inflight_p1)
        kill_p1 <= 1'b1;

      if (redirect_valid) begin
        count  <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        unique case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // ---- p1 datapath: captured request PC and FIFO storage (not reset) ----
  always_ff @(posedge clk) begin
    if (accept)
      ipc_p1 <= pc_p0;
    if (push) begin
      mem_pkt[wr_ptr] <= il1c_packet;
      mem_pc[wr_ptr]  <= ipc_p1;
    end
  end

`ifdef MCPU_FETCH_PERF_CTR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_pkt_count        <= '0;
      perf_il1c_stall_count <= '0;
    end else begin
      if (pop)
        perf_pkt_count <= perf_pkt_count + 32'd1;
      if (il1c_re && !il1c_ready)
        perf_il1c_stall_count <= perf_il1c_stall_count + 32'd1;
    end
  end
`endif

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && ({1'b0, count} == DEPTH_C)));

endmodule

// File: tb/tb_mcpu_fetch_pcgen.sv
module tb_mcpu_fetch_pcgen;

  localparam int DEPTH = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         fetch_en;
  logic         redirect_valid;
  logic [27:0]  redirect_pc;
  logic [27:0]  il1c_addr;
  logic         il1c_re;
  logic [127:0] il1c_packet;
  logic         il1c_ready;
  logic         f2d_valid;
  logic         f2d_ready;
  logic [127:0] f2d_packet;
  logic [27:0]  f2d_pc;
`ifdef MCPU_FETCH_PERF_CTR_EN
  logic [31:0]  perf_pkt_count;
  logic [31:0]  perf_il1c_stall_count;
`endif

  mcpu_fetch_pcgen #(
    .RESET_PC  (32'h0000_0100),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .il1c_addr     (il1c_addr),
    .il1c_re       (il1c_re),
    .il1c_packet   (il1c_packet),
    .il1c_ready    (il1c_ready),
    .f2d_valid     (f2d_valid),
    .f2d_ready     (f2d_ready),
    .f2d_packet    (f2d_packet),
    .f2d_pc        (f2d_pc)
`ifdef MCPU_FETCH_PERF_CTR_EN
    ,
    .perf_pkt_count       (perf_pkt_count),
    .perf_il1c_stall_count(perf_il1c_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Packet content the fake cache returns for a given packet address.
  function automatic logic [127:0] pkt_of(logic [27:0] a);
    return {4'h0, a, 4'hF, ~a, 4'h5, a ^ 28'h5A5A5A5, 4'hC, a + 28'd7};
  endfunction

  // ---------------- fake il1c ----------------
  logic        cache_pend;
  logic [27:0] cache_addr;

  // ---------------- reference model ----------------
  typedef struct {
    logic [27:0]  pc;
    logic [127:0] pkt;
  } ent_t;

  ent_t        mq[$];
  logic [27:0] m_pc;
  bit          m_out;
  logic [27:0] m_opc;
  bit          m_dead;
  logic [31:0] m_pops;
  logic [31:0] m_stalls;

  // Compare process: checks every cycle out of reset, then advances the
  // model and the fake cache across the coming posedge.
  always @(negedge clk) begin
    bit exp_re, acc, rtn, popm;
    ent_t e;
    if (!rst_n) begin
      mq.delete();
      m_pc = 28'h010;
      m_out = 0; m_dead = 0; m_opc = '0;
      m_pops = '0; m_stalls = '0;
      cache_pend = 1'b0;
      cache_addr = '0;
    end else begin
      exp_re = fetch_en && !redirect_valid && ((mq.size() + int'(m_out)) < DEPTH);
      chk("il1c_re", 128'(il1c_re), 128'(exp_re));
      chk("il1c_addr", 128'(il1c_addr), 128'(m_pc));
      chk("f2d_valid", 128'(f2d_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) begin
        chk("f2d_pc", 128'(f2d_pc), 128'(mq[0].pc));
        chk("f2d_packet", f2d_packet, mq[0].pkt);
      end
`ifdef MCPU_FETCH_PERF_CTR_EN
      chk("perf_pkt_count", 128'(perf_pkt_count), 128'(m_pops));
      chk("perf_stall_count", 128'(perf_il1c_stall_count), 128'(m_stalls));
`endif
      acc  = exp_re && il1c_ready;
      rtn  = m_out && il1c_ready;
      popm = (mq.size() != 0) && f2d_ready && !redirect_valid;
      if (popm) m_pops = m_pops + 32'd1;
      if (exp_re && !il1c_ready) m_stalls = m_stalls + 32'd1;
      if (redirect_valid) begin
        mq.delete();
        if (rtn) m_out = 0;
        else if (m_out) m_dead = 1;
        m_pc = redirect_pc;
      end else begin
        if (popm) void'(mq.pop_front());
        if (rtn) begin
          if (!m_dead) begin
            e.pc = m_opc;
            e.pkt = pkt_of(m_opc);
            mq.push_back(e);
          end
          m_out = 0;
          m_dead = 0;
        end
        if (acc) begin
          m_out = 1; m_dead = 0; m_opc = m_pc;
          m_pc = m_pc + 28'd1;
        end
      end
      // Fake cache: remember the accepted address, return it on next ready.
      if (il1c_re && il1c_ready) begin
        cache_pend = 1'b1;
        cache_addr = il1c_addr;
      end else if (cache_pend && il1c_ready) begin
        cache_pend = 1'b0;
      end
    end
  end

  // One cycle of stimulus, returning 2 time units after the posedge so the
  // caller can sample settled outputs.
  task automatic cyc(input logic fe, input logic rv, input logic [27:0] rpc,
                     input logic rdy, input logic frdy);
    @(posedge clk);
    #1;
    fetch_en       = fe;
    redirect_valid = rv;
    redirect_pc    = rpc;
    il1c_ready     = rdy;
    f2d_ready      = frdy;
    il1c_packet    = cache_pend ? pkt_of(cache_addr)
                                : {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
  endtask

  task automatic wait_valid(input string nm, input logic [27:0] exp_pc);
    bit seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (f2d_valid) begin
        seen = 1;
        break;
      end
      cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    end
    if (seen) chk(nm, 128'(f2d_pc), 128'(exp_pc));
    else      chk({nm, "_timeout"}, 128'(0), 128'(1));
  endtask

  initial begin
    rst_n          = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    il1c_ready     = 1'b1;
    f2d_ready      = 1'b1;
    il1c_packet    = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_il1c_re", 128'(il1c_re), 128'(0));
    chk("rst_f2d_valid", 128'(f2d_valid), 128'(0));
    chk("rst_f2d_packet", f2d_packet, 128'(0));
    chk("rst_f2d_pc", 128'(f2d_pc), 128'(0));
    chk("rst_il1c_addr", 128'(il1c_addr), 128'h010);

    // Streaming from RESET_PC=0x100 with an always-ready cache and decode.
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("c0_addr", 128'(il1c_addr), 128'h010);
    chk("c0_re", 128'(il1c_re), 128'(1));
    chk("c0_valid", 128'(f2d_valid), 128'(0));
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("c1_addr", 128'(il1c_addr), 128'h011);
    chk("c1_valid", 128'(f2d_valid), 128'(0));
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("c2_valid", 128'(f2d_valid), 128'(1));
    chk("c2_pc", 128'(f2d_pc), 128'h010);
    chk("c2_pkt", f2d_packet, pkt_of(28'h010));
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("c3_pc", 128'(f2d_pc), 128'h011);
    chk("c3_addr", 128'(il1c_addr), 128'h013);
    for (int k = 4; k < 10; k++) begin
      cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
      chk("stream_pc", 128'(f2d_pc), 128'(28'h010 + 28'(k - 2)));
    end

    // Decode backpressure: FIFO fills, issue stops.
    for (int k = 0; k < 10; k++) cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b0);
    chk("bp_re", 128'(il1c_re), 128'(0));
    chk("bp_valid", 128'(f2d_valid), 128'(1));

    // Redirect with two buffered and one in flight (cache stalled).
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 28'h0400, 1'b0, 1'b1);
    chk("rd_re", 128'(il1c_re), 128'(0));
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("rd_flush", 128'(f2d_valid), 128'(0));
    wait_valid("rd_pc", 28'h0400);

    // Two redirects during a 6-cycle stall: only 0x0800 onward survives.
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 28'h0123, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 28'h0800, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 1'b0, 28'h0, 1'b0, 1'b1);
      chk("stall_addr", 128'(il1c_addr), 128'h0800);
    end
    wait_valid("rr_pc", 28'h0800);

    // PC wrap.
    cyc(1'b1, 1'b1, 28'hFFFFFFF, 1'b1, 1'b1);
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("wrap_addr0", 128'(il1c_addr), 128'hFFFFFFF);
    chk("wrap_re", 128'(il1c_re), 128'(1));
    cyc(1'b1, 1'b0, 28'h0, 1'b1, 1'b1);
    chk("wrap_addr1", 128'(il1c_addr), 128'h0000000);

    // Randomised traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      logic [27:0] rpc;
      rpc = ($urandom_range(3) == 0) ? 28'hFFFFFFF - 28'($urandom_range(3))
                                     : 28'($urandom());
      cyc(1'($urandom_range(99) < 90), 1'($urandom_range(99) < 5), rpc,
          1'($urandom_range(99) < 75), 1'($urandom_range(99) < 70));
    end
    cyc(1'b0, 1'b0, 28'h0, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
